// File: rtl/move_scheduler.sv
// move_scheduler: merges held-button auto-repeat user moves with a one-entry
// autonomous request buffer into at most one bounds-checked command per frame tick.
//
//   state    | meaning
//   S_IDLE   | no button held; next tick with a press issues a move at once
//   S_DELAY  | button held; counting HOLD_TICKS before the first repeat
//   S_REPEAT | button held; repeating every REPEAT_TICKS frame ticks
module move_scheduler #(
  parameter int STEP         = 5,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 479,
  parameter int HOLD_TICKS   = 15,
  parameter int REPEAT_TICKS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [3:0]         btn,
  input  logic               auto_valid,
  input  logic [2:0]         auto_cmd,
  output logic               auto_ready,
  input  logic signed [31:0] Ox,
  input  logic signed [31:0] Oy,
  output logic [2:0]         command,
  output logic               src,
  output logic               blocked
);

  localparam int CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] RPT_LD  = CNT_W'(REPEAT_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_LEFT  = 3'd1;
  localparam logic [2:0] CMD_RIGHT = 3'd2;
  localparam logic [2:0] CMD_UP    = 3'd3;
  localparam logic [2:0] CMD_DOWN  = 3'd4;

  localparam logic signed [31:0] STEP_S  = 32'(STEP);
  localparam logic signed [31:0] X_MIN_S = 32'(X_MIN);
  localparam logic signed [31:0] X_MAX_S = 32'(X_MAX);
  localparam logic signed [31:0] Y_MIN_S = 32'(Y_MIN);
  localparam logic signed [31:0] Y_MAX_S = 32'(Y_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_dir;
  logic [2:0]       w_dir_nxt;
  logic [2:0]       w_dir;
  logic             w_hold_ok;
  logic             w_user_go;

  logic             r_buf_valid;
  logic [2:0]       r_buf_cmd;
  logic             w_auto_go;
  logic             w_accept;
  logic             w_cmd_legal;

  logic [2:0]       w_move;
  logic             w_fits;
  logic [2:0]       w_cmd_nxt;
  logic             w_src_nxt;
  logic             w_blk_nxt;

  logic signed [31:0] w_ox_dec;
  logic signed [31:0] w_ox_inc;
  logic signed [31:0] w_oy_dec;
  logic signed [31:0] w_oy_inc;

  // Lowest set button wins: left > right > up > down.
  always_comb begin
    w_dir = CMD_NONE;
    if (btn[0])      w_dir = CMD_LEFT;
    else if (btn[1]) w_dir = CMD_RIGHT;
    else if (btn[2]) w_dir = CMD_UP;
    else if (btn[3]) w_dir = CMD_DOWN;
  end

  assign w_hold_ok = (w_dir != CMD_NONE) && (w_dir == r_dir);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
      r_dir   <= CMD_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  // A release or direction change drops to idle without moving; the new
  // direction then issues on the following tick from S_IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_user_go   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_tick && (w_dir != CMD_NONE)) begin
          w_user_go   = 1'b1;
          w_dir_nxt   = w_dir;
          w_cnt_nxt   = HOLD_LD;
          w_state_nxt = S_DELAY;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (!w_hold_ok) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
          w_dir_nxt   = CMD_NONE;
        end else if (frame_tick) begin
          if (r_cnt == CNT_ONE) begin
            w_user_go   = 1'b1;
            w_cnt_nxt   = RPT_LD;
            w_state_nxt = S_REPEAT;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_ZERO;
        w_dir_nxt   = CMD_NONE;
      end
    endcase
  end

  assign auto_ready  = !reset && !r_buf_valid;
  assign w_accept    = auto_valid && auto_ready;
  assign w_cmd_legal = (auto_cmd >= CMD_LEFT) && (auto_cmd <= CMD_DOWN);
  assign w_auto_go   = frame_tick && r_buf_valid && !w_user_go;

  // Accept and issue are exclusive: accept needs an empty buffer, issue a full one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_valid <= 1'b0;
      r_buf_cmd   <= CMD_NONE;
    end else if (w_auto_go) begin
      r_buf_valid <= 1'b0;
      r_buf_cmd   <= CMD_NONE;
    end else if (w_accept && w_cmd_legal) begin
      r_buf_valid <= 1'b1;
      r_buf_cmd   <= auto_cmd;
    end
  end

  assign w_ox_dec = Ox - STEP_S;
  assign w_ox_inc = Ox + STEP_S;
  assign w_oy_dec = Oy - STEP_S;
  assign w_oy_inc = Oy + STEP_S;

  always_comb begin
    w_move = CMD_NONE;
    if (w_user_go)      w_move = w_dir;
    else if (w_auto_go) w_move = r_buf_cmd;
  end

  always_comb begin
    w_fits = 1'b0;
    case (w_move)
      CMD_LEFT:  w_fits = (w_ox_dec >= X_MIN_S);
      CMD_RIGHT: w_fits = (w_ox_inc <= X_MAX_S);
      CMD_UP:    w_fits = (w_oy_dec >= Y_MIN_S);
      CMD_DOWN:  w_fits = (w_oy_inc <= Y_MAX_S);
      default:   w_fits = 1'b0;
    endcase
  end

  // A blocked move still counts as consumed; only the outputs differ.
  always_comb begin
    w_cmd_nxt = CMD_NONE;
    w_src_nxt = 1'b0;
    w_blk_nxt = 1'b0;
    if (w_move != CMD_NONE) begin
      if (w_fits) begin
        w_cmd_nxt = w_move;
        w_src_nxt = w_auto_go;
      end else begin
        w_blk_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      command <= CMD_NONE;
      src     <= 1'b0;
      blocked <= 1'b0;
    end else begin
      command <= w_cmd_nxt;
      src     <= w_src_nxt;
      blocked <= w_blk_nxt;
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: directed scenarios plus random traffic, all checked
// against a tick-index reference model of hold/auto-repeat and the request buffer.
module tb_move_scheduler;

  localparam int STEP  = 5;
  localparam int X_MIN = 0;
  localparam int X_MAX = 639;
  localparam int Y_MIN = 0;
  localparam int Y_MAX = 479;
  localparam int HOLD  = 15;
  localparam int RPT   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [3:0] btn;
  logic       auto_valid;
  logic [2:0] auto_cmd;
  logic       auto_ready;
  int         Ox;
  int         Oy;
  logic [2:0] command;
  logic       src;
  logic       blocked;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: held direction (0 = none) and number of ticks seen while held.
  int   m_held = 0;
  int   m_k    = 0;
  int   m_q[$];
  int   e_cmd  = 0;
  bit   e_src  = 1'b0;
  bit   e_blk  = 1'b0;

  always #5 clk = ~clk;

  move_scheduler #(
    .STEP(STEP), .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
    .HOLD_TICKS(HOLD), .REPEAT_TICKS(RPT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn        (btn),
    .auto_valid (auto_valid),
    .auto_cmd   (auto_cmd),
    .auto_ready (auto_ready),
    .Ox         (Ox),
    .Oy         (Oy),
    .command    (command),
    .src        (src),
    .blocked    (blocked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int low_dir(input logic [3:0] b);
    if (b[0]) return 1;
    if (b[1]) return 2;
    if (b[2]) return 3;
    if (b[3]) return 4;
    return 0;
  endfunction

  // Held ticks that move: the first, the one HOLD ticks later, then every RPT.
  function automatic bit issues(input int k);
    if (k == 1 || k == HOLD + 1) return 1'b1;
    if (k > HOLD + 1 && ((k - HOLD - 1) % RPT) == 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit fits(input int d, input int x, input int y);
    case (d)
      1: return (x - STEP) >= X_MIN;
      2: return (x + STEP) <= X_MAX;
      3: return (y - STEP) >= Y_MIN;
      4: return (y + STEP) <= Y_MAX;
      default: return 1'b0;
    endcase
  endfunction

  // One clock cycle: inputs already driven, model advanced, outputs checked after the edge.
  task automatic cyc(input bit tick);
    int d;
    int mv;
    bit ug;
    bit ag;
    bit was_empty;
    frame_tick = tick;
    @(negedge clk);
    chk("auto_ready", auto_ready, (!reset && m_q.size() == 0));
    ug = 0; ag = 0; mv = 0;
    if (reset) begin
      m_held = 0; m_k = 0; m_q.delete();
    end else begin
      d = low_dir(btn);
      was_empty = (m_q.size() == 0);
      if (m_held == 0) begin
        if (tick && d != 0) begin m_held = d; m_k = 1; ug = 1; end
      end else if (d != m_held) begin
        m_held = 0;
      end else if (tick) begin
        m_k++;
        ug = issues(m_k);
      end
      if (ug) mv = m_held;
      else if (tick && !was_empty) begin ag = 1; mv = m_q.pop_front(); end
      if (auto_valid && was_empty && auto_cmd >= 1 && auto_cmd <= 4) m_q.push_back(int'(auto_cmd));
    end
    e_cmd = 0; e_src = 0; e_blk = 0;
    if (mv != 0) begin
      if (fits(mv, Ox, Oy)) begin e_cmd = mv; e_src = ag; end
      else e_blk = 1;
    end
    @(posedge clk);
    #1;
    chk("command", command, e_cmd);
    chk("src", src, e_src);
    chk("blocked", blocked, e_blk);
    frame_tick = 1'b0;
    auto_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; btn = 4'h0; auto_valid = 1'b0; auto_cmd = 3'd0;
    Ox = 320; Oy = 240;
    cyc(1'b1); cyc(1'b0); cyc(1'b1);
    chk("reset_cmd", command, 0);
    chk("reset_ready", auto_ready, 0);
    reset = 1'b0;
    cyc(1'b0);

    // Hold left for 20 ticks: moves after ticks 1, 16, 19 only.
    btn = 4'b0001;
    for (int t = 1; t <= 20; t++) begin
      cyc(1'b1);
      chk("hold_left_cmd", command, (t == 1 || t == 16 || t == 19) ? 1 : 0);
      chk("hold_left_src", src, 0);
      cyc(1'b0);
      chk("hold_left_gap", command, 0);
      cyc(1'b0);
    end
    btn = 4'h0; cyc(1'b0);

    // Left at the edge is blocked, yet the hold still starts.
    Ox = 2; btn = 4'b0001;
    cyc(1'b1);
    chk("edge_cmd", command, 0);
    chk("edge_blocked", blocked, 1);
    cyc(1'b0);
    chk("edge_pulse_len", blocked, 0);
    cyc(1'b1);
    chk("edge_delay_nomove", blocked, 0);
    btn = 4'h0; cyc(1'b0);

    // Auto request wins a tick on which the held user does not move.
    Ox = 320; btn = 4'b0010;
    cyc(1'b1);
    chk("right_first", command, 2);
    for (int t = 0; t < 10; t++) cyc(1'b1);
    auto_valid = 1'b1; auto_cmd = 3'd4;
    cyc(1'b0);
    chk("auto_full", auto_ready, 0);
    cyc(1'b1);
    chk("auto_down_cmd", command, 4);
    chk("auto_down_src", src, 1);
    chk("auto_ready_back", auto_ready, 1);
    btn = 4'h0; cyc(1'b0);

    // Same-tick contention: user first, buffered auto on the next tick.
    auto_valid = 1'b1; auto_cmd = 3'd3;
    cyc(1'b0);
    btn = 4'b0010;
    cyc(1'b1);
    chk("contend_user", command, 2);
    chk("contend_user_src", src, 0);
    cyc(1'b0);
    cyc(1'b1);
    chk("contend_auto", command, 3);
    chk("contend_auto_src", src, 1);
    btn = 4'h0; cyc(1'b0);

    // Illegal auto command is dropped.
    auto_valid = 1'b1; auto_cmd = 3'd6;
    cyc(1'b0);
    chk("illegal_ready", auto_ready, 1);
    cyc(1'b1);
    chk("illegal_cmd", command, 0);
    chk("illegal_blocked", blocked, 0);

    // Up into repeat, switch to down, then reset mid-hold with a buffered request.
    btn = 4'b0100;
    for (int t = 0; t < 17; t++) cyc(1'b1);
    btn = 4'b1000;
    cyc(1'b1);
    chk("switch_nomove", command, 0);
    cyc(1'b1);
    chk("switch_down", command, 4);
    auto_valid = 1'b1; auto_cmd = 3'd1;
    cyc(1'b0);
    cyc(1'b1);
    reset = 1'b1;
    cyc(1'b1);
    chk("rst_cmd", command, 0);
    cyc(1'b1);
    chk("rst_ready", auto_ready, 0);
    reset = 1'b0;
    cyc(1'b1);
    chk("post_rst_down", command, 4);
    btn = 4'h0; cyc(1'b0);

    // Random traffic near and away from the bounds.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(199) == 0) reset = 1'b1;
      else if (reset && $urandom_range(2) == 0) reset = 1'b0;
      if ($urandom_range(14) == 0) btn = ($urandom_range(2) == 0) ? 4'h0 : 4'($urandom_range(15));
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: begin Ox = int'($urandom_range(12)); Oy = int'($urandom_range(12)); end
          1: begin Ox = 627 + int'($urandom_range(12)); Oy = 467 + int'($urandom_range(12)); end
          2: begin Ox = 320; Oy = 240; end
          default: begin Ox = int'($urandom_range(700)) - 30; Oy = int'($urandom_range(540)) - 30; end
        endcase
      end
      auto_valid = ($urandom_range(3) == 0);
      auto_cmd   = 3'($urandom_range(7));
      cyc($urandom_range(2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
